// File: rtl/receiver_pkg.sv
// Shared receiver ring-buffer parameters, common to the capture stage and the reader.
package receiver_pkg;

  localparam int unsigned DEF_ADDR_W = 15;
  localparam int unsigned DEF_DEPTH  = 1 << DEF_ADDR_W;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_GUARD  = 4;
  localparam int unsigned PORT_AW    = 16;
  localparam int unsigned CNT_W      = 8;

endpackage

// File: rtl/reader_out_fifo.sv
// Two-entry output FIFO; head is a dedicated register so it stays put while the consumer stalls.
module reader_out_fifo
  import receiver_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              do_push_c, do_pop_c;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    do_pop_c  = pop && (count_q != 2'd0);
    do_push_c = push && ((count_q != 2'd2) || do_pop_c);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({do_push_c, do_pop_c})
        2'b10: begin
          if (count_q == 2'd0) head_d = push_data;
          else                 tail_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new sample lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_d = push_data;
          end else begin
            head_d = tail_q;
            tail_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/receiver_buffer_reader.sv
// Reads the receiver sample ring behind the capture write pointer and streams samples in order,
// resynchronising to the write pointer when unread data is about to be overwritten.
module receiver_buffer_reader
  import receiver_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned GUARD  = DEF_GUARD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PORT_AW-1:0] wr_addr,
  output logic               rd_en,
  output logic [PORT_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun,
  output logic [CNT_W-1:0]   overrun_count
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LVL_W  = ADDR_W + 2;
  localparam int unsigned THRESH = DEPTH - GUARD;

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              inflight_q, inflight_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d;
  logic [1:0]        fifo_count;
  logic              pop_c, push_c, issue_c, resync_c;
  logic [2:0]        occ_c;
  logic [LVL_W-1:0]  level_nxt_c;
  logic              wr_addr_unused_c;

  assign wr_addr_unused_c = ^wr_addr[PORT_AW-1:ADDR_W];
  assign out_valid        = (fifo_count != 2'd0);
  assign pop_c            = out_valid & out_ready;

  // Issue/level tracking; an overrun overrides the normal pointer advance and suppresses issue.
  always_comb begin
    occ_c       = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_c);
    issue_c     = (level_q != '0) && (occ_c < 3'd2);
    level_nxt_c = LVL_W'(level_q) + LVL_W'(wr_en) - LVL_W'(issue_c);
    resync_c    = (level_nxt_c >= LVL_W'(THRESH));
    rd_en       = issue_c & ~resync_c;
    push_c      = inflight_q & ~resync_c;
    rd_ptr_d    = rd_ptr_q + ADDR_W'(rd_en);
    level_d     = level_nxt_c[ADDR_W:0];
    inflight_d  = rd_en;
    overrun_d   = 1'b0;
    ovr_cnt_d   = ovr_cnt_q;
    if (resync_c) begin
      // Jump to the next address the capture stage will write.
      rd_ptr_d   = wr_en ? (wr_addr[ADDR_W-1:0] + ADDR_W'(1))
                         : (rd_ptr_q + level_q[ADDR_W-1:0]);
      level_d    = '0;
      inflight_d = 1'b0;
      overrun_d  = 1'b1;
      if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
      overrun_q  <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      overrun_q  <= overrun_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  reader_out_fifo #(
    .DATA_W (DATA_W)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (resync_c),
    .push      (push_c),
    .push_data (rd_data),
    .pop       (pop_c),
    .head      (out_data),
    .count     (fifo_count)
  );

  assign rd_addr       = PORT_AW'(rd_ptr_q);
  assign overrun       = overrun_q;
  assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_receiver_buffer_reader.sv
// Directed bench for receiver_buffer_reader: full-size ring plus a small ring for fast overrun saturation.
module tb_receiver_buffer_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, out_ready = 1'b0;
  logic [15:0] wr_addr = 16'd0, rd_addr;
  logic        rd_en, out_valid, overrun;
  logic [15:0] rd_data = 16'd0, out_data;
  logic [7:0]  overrun_count;

  logic        wr_en2 = 1'b0, out_ready2 = 1'b0;
  logic [15:0] wr_addr2 = 16'd0, rd_addr2;
  logic        rd_en2, out_valid2, overrun2;
  logic [15:0] rd_data2 = 16'd0, out_data2;
  logic [7:0]  overrun_count2;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] wa = 16'd0;
  logic [15:0] wa2 = 16'd0;

  always #5 clk = ~clk;

  receiver_buffer_reader dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .overrun_count(overrun_count)
  );

  receiver_buffer_reader #(.ADDR_W(5), .DATA_W(16), .GUARD(4)) dut_small (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_addr(wr_addr2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .overrun(overrun2), .overrun_count(overrun_count2)
  );

  // RAM models: mem[a] = a, one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= {1'b0, rd_addr[14:0]};
  always @(posedge clk) if (rd_en2) rd_data2 <= {11'd0, rd_addr2[4:0]};

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (wr_en) wa = wa + 16'd1;
    if (wr_en2) wa2 = wa2 + 16'd1;
    wr_addr  = wa;
    wr_addr2 = wa2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0; out_ready = 1'b0; wr_en2 = 1'b0; out_ready2 = 1'b0;
    wa = 16'd0; wa2 = 16'd0; wr_addr = 16'd0; wr_addr2 = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", rd_en); else n_pass++;
    n_checks++; if (rd_addr !== 16'd0) $display("FAIL reset_rd_addr got %0d want 0", rd_addr); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'd0) $display("FAIL reset_out_data got %0d want 0", out_data); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
    n_checks++; if (overrun_count !== 8'd0) $display("FAIL reset_overrun_count got %0d want 0", overrun_count); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    wr_en = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (c >= 3)) $display("FAIL stream_valid c=%0d got %b want %b", c, out_valid, (c >= 3));
      else n_pass++;
      if (c >= 3) begin
        n_checks++;
        if (out_data !== 16'(c - 3)) $display("FAIL stream_data c=%0d got %0d want %0d", c, out_data, c - 3);
        else n_pass++;
      end
      if (c >= 1) begin
        n_checks++;
        if (rd_en !== 1'b1 || rd_addr !== 16'(c - 1))
          $display("FAIL stream_read c=%0d got en=%b addr=%0d want en=1 addr=%0d", c, rd_en, rd_addr, c - 1);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_toggle();
    logic [15:0] exp_next;
    logic [15:0] held;
    logic        stalled;
    do_reset();
    exp_next = 16'd0; held = 16'd0; stalled = 1'b0;
    wr_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c % 2 == 0);
      @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held)
          $display("FAIL toggle_hold c=%0d got v=%b d=%0d want v=1 d=%0d", c, out_valid, out_data, held);
        else n_pass++;
      end
      stalled = 1'b0;
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (out_data !== exp_next) $display("FAIL toggle_data c=%0d got %0d want %0d", c, out_data, exp_next);
        else n_pass++;
        exp_next = exp_next + 16'd1;
      end else if (out_valid === 1'b1) begin
        stalled = 1'b1;
        held = out_data;
      end
      next_cycle();
    end
    n_checks++;
    if (exp_next !== 16'd18) $display("FAIL toggle_count got %0d want 18", exp_next); else n_pass++;
  endtask

  task automatic test_overrun_wrap();
    int          pulses;
    int          first;
    int          delivered;
    logic        started;
    logic [15:0] exp_rd;
    logic [15:0] exp_out;
    do_reset();
    pulses = 0; first = -1;
    wr_en = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 32768; c++) begin
      @(negedge clk);
      if (overrun === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      next_cycle();
    end
    n_checks++; if (pulses != 1) $display("FAIL ovr_pulses got %0d want 1", pulses); else n_pass++;
    n_checks++; if (first != 32766) $display("FAIL ovr_cycle got %0d want 32766", first); else n_pass++;
    n_checks++; if (overrun_count !== 8'd1) $display("FAIL ovr_count got %0d want 1", overrun_count); else n_pass++;
    // Resync landed at 32766, so the resumed stream also crosses the ring wrap.
    out_ready = 1'b1;
    exp_rd = 16'd32767; exp_out = 16'd32766; started = 1'b0; delivered = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (rd_en === 1'b1) begin
        n_checks++;
        if (rd_addr !== exp_rd) $display("FAIL wrap_rd_addr k=%0d got %0d want %0d", c, rd_addr, exp_rd);
        else n_pass++;
        exp_rd = (exp_rd + 16'd1) & 16'h7fff;
      end
      if (started) begin
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL wrap_bubble k=%0d got %b want 1", c, out_valid); else n_pass++;
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (out_data !== exp_out) $display("FAIL wrap_data k=%0d got %0d want %0d", c, out_data, exp_out);
        else n_pass++;
        exp_out = (exp_out + 16'd1) & 16'h7fff;
        started = 1'b1;
        delivered++;
      end
      next_cycle();
    end
    n_checks++; if (delivered != 13) $display("FAIL wrap_delivered got %0d want 13", delivered); else n_pass++;
  endtask

  task automatic test_saturate();
    int pulses;
    int cyc;
    int first;
    int second;
    do_reset();
    pulses = 0; cyc = 0; first = -1; second = -1;
    wr_en2 = 1'b1; out_ready2 = 1'b0;
    while (cyc < 10000 && pulses < 300) begin
      @(negedge clk);
      if (overrun2 === 1'b1) begin
        pulses++;
        if (pulses == 1) first = cyc;
        if (pulses == 2) second = cyc;
        if (pulses == 1 || pulses == 200) begin
          n_checks++;
          if (overrun_count2 !== 8'(pulses))
            $display("FAIL sat_count_at_%0d got %0d want %0d", pulses, overrun_count2, pulses);
          else n_pass++;
        end
      end
      next_cycle();
      cyc++;
    end
    n_checks++; if (first != 30) $display("FAIL sat_first got %0d want 30", first); else n_pass++;
    n_checks++; if (second != 60) $display("FAIL sat_second got %0d want 60", second); else n_pass++;
    n_checks++; if (pulses != 300) $display("FAIL sat_pulses got %0d want 300", pulses); else n_pass++;
    n_checks++; if (overrun_count2 !== 8'd255) $display("FAIL sat_final got %0d want 255", overrun_count2); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_en = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) next_cycle();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", out_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (rd_addr !== 16'd0) $display("FAIL mid_rd_addr got %0d want 0", rd_addr); else n_pass++;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL mid_rd_en got %b want 0", rd_en); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_addr = wa;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (rd_en !== 1'b1 || rd_addr !== 16'd0)
          $display("FAIL mid_restart_rd got en=%b addr=%0d want en=1 addr=0", rd_en, rd_addr);
        else n_pass++;
      end
      if (c >= 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'(c - 3))
          $display("FAIL mid_restart_data c=%0d got v=%b d=%0d want v=1 d=%0d", c, out_valid, out_data, c - 3);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_toggle();
    test_overrun_wrap();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
